// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: read-collision mode encodings
// and the state type of the clear sequencer.
package ram_pkg;

    localparam int RD_WRITE_FIRST = 0;
    localparam int RD_READ_FIRST  = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram2p_if.sv
// Bus bundle for ram2p: write port, read port and clear handshake.
interface ram2p_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
);
    localparam int NBE = DATA_WIDTH / BYTE_WIDTH;

    logic                  clr;
    logic                  busy;
    logic                  we;
    logic [NBE-1:0]        be;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;

    modport master (
        output clr, we, be, waddr, din, rd_en, raddr,
        input  busy, dout, dout_valid
    );

    modport slave (
        input  clr, we, be, waddr, din, rd_en, raddr,
        output busy, dout, dout_valid
    );

endinterface

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps CLEAR_VALUE over every word, one per cycle, on a
// clr pulse or right after reset, and exposes that sweep as a write port.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int                  RAM_SIZE       = 256,
    parameter int                  ADDR_WIDTH     = 8,
    parameter int                  DATA_WIDTH     = 8,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    output logic                  cw_en,
    output logic [ADDR_WIDTH-1:0] cw_addr,
    output logic [DATA_WIDTH-1:0] cw_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_SIZE - 1);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    // Armed during reset so the sweep starts on the first cycle after release.
    logic                  init_q, init_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            init_q  <= (CLEAR_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr || init_q) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q == ST_CLEAR);
    assign cw_en   = busy;
    assign cw_addr = cnt_q;
    assign cw_data = CLEAR_VALUE;

endmodule

// File: rtl/ram2p.sv
// Simple dual-port RAM with byte-lane writes, write-first or read-first
// collision handling, optional output register and a hardware clear sweep.
module ram2p
    import ram_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    RAM_SIZE       = 256,
    parameter int                    ADDR_WIDTH     = $clog2(RAM_SIZE),
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    RD_MODE        = RD_WRITE_FIRST,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter string                 ROMFILE        = ""
) (
    input  logic  clk,
    input  logic  rst,
    ram2p_if.slave bus
);

    localparam int NBE    = DATA_WIDTH / BYTE_WIDTH;
    localparam int STAGES = 1 + OUT_REG;

    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bw_chk
        $error("ram2p: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if ((ROMFILE != "") && (CLEAR_ON_RESET != 0)) begin : g_rom_chk
        $error("ram2p: ROMFILE preload conflicts with CLEAR_ON_RESET");
    end

    logic                  busy, cw_en;
    logic [ADDR_WIDTH-1:0] cw_addr;
    logic [DATA_WIDTH-1:0] cw_data;

    ram_clear_seq #(
        .RAM_SIZE      (RAM_SIZE),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET),
        .CLEAR_VALUE   (CLEAR_VALUE)
    ) u_clear (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.clr),
        .busy   (busy),
        .cw_en  (cw_en),
        .cw_addr(cw_addr),
        .cw_data(cw_data)
    );

    assign bus.busy = busy;

    logic                  waddr_ok, raddr_ok, wr_fire, rd_fire;
    logic                  mem_we;
    logic [NBE-1:0]        mem_be;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // The clear sweep owns the write port whenever it runs.
    always_comb begin
        waddr_ok  = 32'(bus.waddr) < RAM_SIZE;
        raddr_ok  = 32'(bus.raddr) < RAM_SIZE;
        wr_fire   = bus.we && !busy && waddr_ok;
        rd_fire   = bus.rd_en && !busy;
        mem_we    = wr_fire;
        mem_be    = bus.be;
        mem_waddr = bus.waddr;
        mem_wdata = bus.din;
        if (cw_en) begin
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_waddr = cw_addr;
            mem_wdata = cw_data;
        end
    end

    // Plain array with registered read (old data on collision) so it maps to block RAM.
    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];
    logic [DATA_WIDTH-1:0] mem_rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBE; i++) begin
            if (mem_we && mem_be[i])
                mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (rd_fire && raddr_ok)
            mem_rdata_q <= mem[bus.raddr];
    end

    logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
    logic [NBE-1:0]        byp_mask_q, byp_mask_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic                  zero_q, zero_d;

    // Side-band state follows each accepted read so dout holds between reads.
    always_comb begin
        byp_mask_d    = byp_mask_q;
        byp_data_d    = byp_data_q;
        zero_d        = zero_q;
        vld_pipe_d[1] = rd_fire;
        for (int s = 2; s <= STAGES; s++)
            vld_pipe_d[s] = vld_pipe_q[s-1];
        if (rd_fire) begin
            zero_d     = !raddr_ok;
            byp_data_d = bus.din;
            byp_mask_d = (RD_MODE == RD_WRITE_FIRST && wr_fire && bus.waddr == bus.raddr)
                         ? bus.be : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            byp_mask_q <= '0;
            byp_data_q <= '0;
            zero_q     <= 1'b1;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            byp_mask_q <= byp_mask_d;
            byp_data_q <= byp_data_d;
            zero_q     <= zero_d;
        end
    end

    logic [DATA_WIDTH-1:0] rdata_m;

    always_comb begin
        rdata_m = '0;
        for (int i = 0; i < NBE; i++)
            rdata_m[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_mask_q[i]
                ? byp_data_q[i*BYTE_WIDTH +: BYTE_WIDTH]
                : mem_rdata_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (zero_q)
            rdata_m = '0;
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        always_comb begin
            dout_d = dout_q;
            if (vld_pipe_q[1])
                dout_d = rdata_m;
        end

        always_ff @(posedge clk) begin
            if (!rst) dout_q <= '0;
            else      dout_q <= dout_d;
        end

        assign bus.dout = dout_q;
    end else begin : g_noreg
        assign bus.dout = rdata_m;
    end

    assign bus.dout_valid = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_ram2p.sv
// Directed bench for ram2p: a 16-bit write-first instance with reset clear,
// and an 8-bit read-first, output-registered, 12-word instance.
module tb_ram2p;

    logic clk, rst0, rst1;
    int   n_pass, n_total;

    ram2p_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8)) b0 ();
    ram2p_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4), .BYTE_WIDTH(8)) b1 ();

    ram2p #(
        .DATA_WIDTH(16), .RAM_SIZE(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h0000)
    ) u_ram0 (.clk(clk), .rst(rst0), .bus(b0));

    ram2p #(
        .DATA_WIDTH(8), .RAM_SIZE(12), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h00)
    ) u_ram1 (.clk(clk), .rst(rst1), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [3:0]  waddr;
        logic [15:0] din;
        logic        rd;
        logic [3:0]  raddr;
        logic        evld;
        logic [15:0] edout;
    } vec_t;

    vec_t vt [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle0();
        b0.clr = 1'b0; b0.we = 1'b0; b0.be = 2'b00; b0.waddr = '0;
        b0.din = '0; b0.rd_en = 1'b0; b0.raddr = '0;
    endtask

    task automatic rd0(input logic [3:0] a, input logic [15:0] exp, input string name);
        b0.rd_en = 1'b1; b0.raddr = a;
        step();
        b0.rd_en = 1'b0;
        check({name, "_vld"}, 32'(b0.dout_valid), 32'd1);
        check({name, "_dout"}, 32'(b0.dout), 32'(exp));
    endtask

    task automatic wr1(input logic [3:0] a, input logic [7:0] d);
        b1.we = 1'b1; b1.be = 1'b1; b1.waddr = a; b1.din = d;
        step();
        b1.we = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] a, input logic [7:0] exp, input string name);
        b1.rd_en = 1'b1; b1.raddr = a;
        step();
        b1.rd_en = 1'b0;
        step();
        check({name, "_vld"}, 32'(b1.dout_valid), 32'd1);
        check({name, "_dout"}, 32'(b1.dout), 32'(exp));
    endtask

    initial begin
        int   n;
        logic vseen;
        n_pass = 0; n_total = 0;
        rst0 = 1'b0; rst1 = 1'b0;
        idle0();
        b1.clr = 1'b0; b1.we = 1'b0; b1.be = 1'b0; b1.waddr = '0;
        b1.din = '0; b1.rd_en = 1'b0; b1.raddr = '0;

        // ---------------- instance 0: reset sweep ----------------
        step(); step(); step();
        check("rst_busy", 32'(b0.busy), 32'd0);
        check("rst_vld", 32'(b0.dout_valid), 32'd0);
        check("rst_dout", 32'(b0.dout), 32'd0);
        rst0 = 1'b1;
        step();
        check("busy_rise", 32'(b0.busy), 32'd1);
        n = 0;
        while (b0.busy && n < 100) begin n++; step(); end
        check("init_busy_len", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++)
            rd0(4'(a), 16'h0000, $sformatf("zero_rd%0d", a));

        // ---------------- instance 0: vector table ----------------
        vt[0]  = '{1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 4'd0, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 4'd0, 1'b0, 16'h0000};
        vt[2]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 16'hAB34};
        vt[3]  = '{1'b1, 2'b11, 4'd5, 16'h0011, 1'b0, 4'd0, 1'b0, 16'hAB34};
        vt[4]  = '{1'b1, 2'b11, 4'd5, 16'h0022, 1'b1, 4'd5, 1'b1, 16'h0022};
        vt[5]  = '{1'b1, 2'b10, 4'd5, 16'hFF99, 1'b1, 4'd5, 1'b1, 16'hFF22};
        vt[6]  = '{1'b1, 2'b11, 4'd7, 16'h7777, 1'b1, 4'd5, 1'b1, 16'hFF22};
        vt[7]  = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd7, 1'b1, 16'h7777};
        vt[8]  = '{1'b1, 2'b00, 4'd7, 16'h0000, 1'b1, 4'd7, 1'b1, 16'h7777};
        vt[9]  = '{1'b1, 2'b11, 4'd3, 16'h5555, 1'b1, 4'd3, 1'b1, 16'h5555};
        vt[10] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b0, 4'd0, 1'b0, 16'h5555};
        vt[11] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h5555};
        for (int i = 0; i < 12; i++) begin
            b0.we = vt[i].we; b0.be = vt[i].be; b0.waddr = vt[i].waddr;
            b0.din = vt[i].din; b0.rd_en = vt[i].rd; b0.raddr = vt[i].raddr;
            step();
            check($sformatf("vec%0d_vld", i), 32'(b0.dout_valid), 32'(vt[i].evld));
            check($sformatf("vec%0d_dout", i), 32'(b0.dout), 32'(vt[i].edout));
        end
        idle0();

        // ---------------- instance 0: clr, reset mid-sweep ----------------
        b0.clr = 1'b1; b0.rd_en = 1'b1; b0.raddr = 4'd3;
        step();
        idle0();
        check("preclr_rd_vld", 32'(b0.dout_valid), 32'd1);
        check("preclr_rd_dout", 32'(b0.dout), 32'h5555);
        check("clr_busy", 32'(b0.busy), 32'd1);
        for (int k = 0; k < 7; k++) step();
        rst0 = 1'b0;
        step(); step();
        check("midrst_busy", 32'(b0.busy), 32'd0);
        check("midrst_vld", 32'(b0.dout_valid), 32'd0);
        check("midrst_dout", 32'(b0.dout), 32'd0);
        rst0 = 1'b1;
        step();
        check("restart_busy", 32'(b0.busy), 32'd1);
        b0.we = 1'b1; b0.be = 2'b11; b0.waddr = 4'd9; b0.din = 16'hBEEF;
        b0.rd_en = 1'b1; b0.raddr = 4'd3; b0.clr = 1'b1;
        n = 0; vseen = 1'b0;
        while (b0.busy && n < 100) begin
            n++; vseen = vseen | b0.dout_valid; step();
        end
        idle0();
        vseen = vseen | b0.dout_valid;
        check("restart_busy_len", 32'(n), 32'd16);
        check("busy_rd_ignored", 32'(vseen), 32'd0);
        step();
        check("clr_no_restart", 32'(b0.busy), 32'd0);
        rd0(4'd9, 16'h0000, "busy_wr_ignored");
        rd0(4'd3, 16'h0000, "cleared3");
        rd0(4'd5, 16'h0000, "cleared5");

        // ---------------- instance 1: read-first, OUT_REG, 12 words ----------------
        step();
        check("r1_rst_dout", 32'(b1.dout), 32'd0);
        check("r1_rst_vld", 32'(b1.dout_valid), 32'd0);
        rst1 = 1'b1;
        step();
        check("r1_busy_a", 32'(b1.busy), 32'd0);
        step();
        check("r1_busy_b", 32'(b1.busy), 32'd0);
        for (int a = 0; a < 4; a++) wr1(4'(a), 8'hA0 + 8'(a));
        wr1(4'd5, 8'h11);
        wr1(4'd11, 8'hC3);
        wr1(4'd13, 8'h5A);
        for (int c = 0; c < 8; c++) begin
            logic       ev;
            logic [7:0] ed;
            ev = (c >= 2 && c <= 5);
            ed = (c < 2) ? 8'h00 : ((c <= 5) ? 8'hA0 + 8'(c - 2) : 8'hA3);
            check($sformatf("pipe_c%0d_vld", c), 32'(b1.dout_valid), 32'(ev));
            check($sformatf("pipe_c%0d_dout", c), 32'(b1.dout), 32'(ed));
            b1.rd_en = (c < 4); b1.raddr = 4'(c);
            step();
        end
        b1.rd_en = 1'b0;

        b1.we = 1'b1; b1.be = 1'b1; b1.waddr = 4'd5; b1.din = 8'h22;
        b1.rd_en = 1'b1; b1.raddr = 4'd5;
        step();
        b1.we = 1'b0;
        step();
        b1.rd_en = 1'b0;
        check("rf_coll_vld", 32'(b1.dout_valid), 32'd1);
        check("rf_coll_dout", 32'(b1.dout), 32'h11);
        step();
        check("rf_after_vld", 32'(b1.dout_valid), 32'd1);
        check("rf_after_dout", 32'(b1.dout), 32'h22);

        rd1(4'd13, 8'h00, "oor_read");
        rd1(4'd11, 8'hC3, "last_addr");
        rd1(4'd5, 8'h22, "no_alias");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram2p.md
RAM2P -- requirements
Module: ram2p

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter RAM_SIZE, default 256, number of words; it need not be a power of two.
REQ-003 Parameter ADDR_WIDTH, default $clog2(RAM_SIZE), address width.
REQ-004 Parameter BYTE_WIDTH, default 8, lane width; NBE = DATA_WIDTH/BYTE_WIDTH; an indivisible DATA_WIDTH shall be an elaboration error.
REQ-005 Parameter RD_MODE, default 0; 0 = write-first (bypass), 1 = read-first (old data).
REQ-006 Parameter OUT_REG, default 0; 1 adds one output register stage.
REQ-007 Parameter CLEAR_ON_RESET, default 1; 1 clears the memory after reset.
REQ-008 Parameter CLEAR_VALUE, default 0, the word written during a clear.
REQ-009 Parameter ROMFILE, default "", hex preload file; a non-empty ROMFILE with CLEAR_ON_RESET=1 shall be an elaboration error.
REQ-010 clk  in  1  single clock; all logic on posedge.
REQ-011 rst  in  1  reset; synchronous, active-low.
REQ-012 clr  in  1  one-cycle request to clear the whole memory.
REQ-013 busy  out  1  high while a clear is in progress.
REQ-014 we  in  1  write enable.
REQ-015 be  in  NBE  byte-lane write enables.
REQ-016 waddr  in  ADDR_WIDTH  write address.
REQ-017 din  in  DATA_WIDTH  write data.
REQ-018 rd_en  in  1  read request.
REQ-019 raddr  in  ADDR_WIDTH  read address.
REQ-020 dout  out  DATA_WIDTH  read data.
REQ-021 dout_valid  out  1  one-cycle pulse that qualifies dout.

Function
REQ-022 A write with we=1 and busy=0 shall update only the lanes whose be bit is 1, at the clock edge.
REQ-023 A read with rd_en=1 and busy=0 shall present data on dout, with dout_valid=1, exactly 1+OUT_REG cycles after the request.
REQ-024 Reads shall be fully pipelined: back-to-back rd_en yields back-to-back dout_valid.
REQ-025 dout shall hold its last value when no read completes; dout_valid=0 in those cycles.
REQ-026 Read and write to the same address in the same cycle, with RD_MODE=0: dout = din on enabled lanes and old contents on the other lanes.
REQ-027 The same collision with RD_MODE=1: dout = old contents on all lanes.
REQ-028 Reads and writes to different addresses in the same cycle shall not interact.
REQ-029 Address >= RAM_SIZE: the write is ignored; the read returns 0 with dout_valid=1.
REQ-030 The clear FSM has two states, IDLE and CLEAR.
REQ-031 IDLE->CLEAR on clr=1, or on the first cycle after reset release when CLEAR_ON_RESET=1.
REQ-032 In CLEAR, the FSM writes CLEAR_VALUE to address cnt (starting at 0), one word per cycle.
REQ-033 CLEAR->IDLE after address RAM_SIZE-1 is written; a clear therefore takes exactly RAM_SIZE cycles.
REQ-034 busy=1 in CLEAR; while busy, we, rd_en and clr shall be ignored.
REQ-035 Reads already in the pipeline when busy rises shall complete with their pre-clear data.
REQ-036 clr=1 while in CLEAR shall not restart the sweep.

Reset
REQ-037 While rst=0: dout=0, dout_valid=0, the pipeline is flushed, FSM=IDLE and cnt=0.
REQ-038 busy shall rise in the first cycle after reset release when CLEAR_ON_RESET=1, and otherwise stay 0.
REQ-039 Reset mid-clear shall abort the sweep; with CLEAR_ON_RESET=1 the sweep restarts at address 0.
REQ-040 Reset shall not alter memory contents directly; only the clear sweep or writes change them.

Structure
REQ-041 Package ram_pkg holds the RD_MODE encodings (RD_WRITE_FIRST=0, RD_READ_FIRST=1) and the clear-FSM state type.
REQ-042 Sub-module ram_clear_seq holds the FSM, cnt and busy, and provides the clear write port muxed ahead of the user write port.
REQ-043 The memory array shall be inferable as block RAM; collision bypass and lane merge are done outside the array.

Verification
REQ-044 CLEAR_ON_RESET=1, RAM_SIZE=16: release rst -> busy high for exactly 16 cycles; afterwards reads of addresses 0..15 all return 0.
REQ-045 DATA_WIDTH=16, write 0xABCD to address 3 with be=2'b11, then write 0x1234 with be=2'b01 -> reading address 3 returns 0xAB34.
REQ-046 Address 5 holds 0x11; same-cycle write of 0x22 and read of address 5 -> dout=0x22 with RD_MODE=0, dout=0x11 with RD_MODE=1.
REQ-047 OUT_REG=1, rd_en held for 4 cycles on addresses 0..3 -> dout_valid high for cycles 2..5 (request in cycle 0), data in order.
REQ-048 RAM_SIZE=16: pulse clr, assert rst at sweep cycle 7 -> after reset release the sweep restarts at 0 and busy lasts 16 cycles; a we issued during busy leaves memory unchanged.
REQ-049 RAM_SIZE=12: write to address 13 is ignored and a read of address 13 returns 0 with dout_valid=1.
